// File: rtl/mem_bus_controller_if.sv
// rtl/mem_bus_controller_if.sv - requester, buffer and SRAM signal bundle for mem_bus_controller
interface mem_bus_controller_if #(parameter int ADDR_WIDTH = 16);
  logic                  reqA;
  logic                  weA;
  logic [ADDR_WIDTH-1:0] addrA;
  logic [7:0]            wdataA;
  logic                  reqB;
  logic                  weB;
  logic [ADDR_WIDTH-1:0] addrB;
  logic [7:0]            wdataB;
  logic                  ackA;
  logic                  ackB;
  logic [7:0]            rdData;
  logic                  busy;
  logic                  bufOe;
  logic                  bufWr;
  logic [7:0]            wdataOut;
  logic [7:0]            internalDataIn;
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic                  ramCs_n;
  logic                  ramOe_n;
  logic                  ramWe_n;

  // master = requesters plus the buffer/SRAM environment
  modport master (
    output reqA, weA, addrA, wdataA, reqB, weB, addrB, wdataB, internalDataIn,
    input  ackA, ackB, rdData, busy, bufOe, bufWr, wdataOut, ramAddr, ramCs_n, ramOe_n, ramWe_n
  );

  modport slave (
    input  reqA, weA, addrA, wdataA, reqB, weB, addrB, wdataB, internalDataIn,
    output ackA, ackB, rdData, busy, bufOe, bufWr, wdataOut, ramAddr, ramCs_n, ramOe_n, ramWe_n
  );
endinterface

// File: rtl/mem_bus_controller.sv
// rtl/mem_bus_controller.sv - two-port round-robin SRAM cycle sequencer driving the data buffer
module mem_bus_controller #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 2
) (
  input logic                clk,
  input logic                rst,
  mem_bus_controller_if.slave bus
);

  localparam int              WAIT_EFF  = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
  localparam logic [3:0]      LAST_WAIT = 4'(WAIT_EFF - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, TURN} state_t;

  state_t                state, state_nx;
  logic [3:0]            wait_cnt, wait_cnt_nx;
  logic                  last_grant_b, last_grant_b_nx;
  logic                  grant_b, grant_b_nx;
  logic                  is_write, is_write_nx;
  logic                  pick_b;
  logic                  rd_capture;
  logic [ADDR_WIDTH-1:0] ram_addr, ram_addr_nx;
  logic [7:0]            wdata_out, wdata_out_nx;
  logic [7:0]            rd_data, rd_data_nx;
  logic                  ack_a, ack_a_nx, ack_b, ack_b_nx;
  logic                  busy_q, busy_nx;
  logic                  buf_oe, buf_oe_nx, buf_wr, buf_wr_nx;
  logic                  cs_n, cs_n_nx, oe_n, oe_n_nx, we_n, we_n_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    wait_cnt_nx     = wait_cnt;
    last_grant_b_nx = last_grant_b;
    grant_b_nx      = grant_b;
    is_write_nx     = is_write;
    ram_addr_nx     = ram_addr;
    wdata_out_nx    = wdata_out;
    pick_b          = 1'b0;
    rd_capture      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.reqA || bus.reqB) begin
          // on a tie the port that did not win last time takes the bus
          pick_b          = bus.reqB && (!bus.reqA || !last_grant_b);
          grant_b_nx      = pick_b;
          last_grant_b_nx = pick_b;
          is_write_nx     = pick_b ? bus.weB    : bus.weA;
          ram_addr_nx     = pick_b ? bus.addrB  : bus.addrA;
          wdata_out_nx    = pick_b ? bus.wdataB : bus.wdataA;
          state_nx        = SETUP;
        end
      end
      SETUP: begin
        wait_cnt_nx = 4'd0;
        state_nx    = ACCESS;
      end
      ACCESS: begin
        if (wait_cnt == LAST_WAIT) begin
          rd_capture = !is_write;
          state_nx   = TURN;
        end else begin
          wait_cnt_nx = wait_cnt + 4'd1;
        end
      end
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    rd_data_nx = rd_capture ? bus.internalDataIn : rd_data;

    // strobes are decoded from the state being entered so they leave a flop
    ack_a_nx  = 1'b0;
    ack_b_nx  = 1'b0;
    buf_oe_nx = 1'b0;
    buf_wr_nx = 1'b0;
    cs_n_nx   = 1'b1;
    oe_n_nx   = 1'b1;
    we_n_nx   = 1'b1;
    busy_nx   = (state_nx != IDLE);

    case (state_nx)
      SETUP, ACCESS: begin
        cs_n_nx = 1'b0;
        if (is_write_nx) begin
          buf_wr_nx = 1'b1;
          we_n_nx   = (state_nx == SETUP);
        end else begin
          buf_oe_nx = 1'b1;
          oe_n_nx   = 1'b0;
        end
      end
      TURN: begin
        buf_wr_nx = is_write_nx;
        ack_a_nx  = !grant_b_nx;
        ack_b_nx  = grant_b_nx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt     <= 4'd0;
      last_grant_b <= 1'b1;
      grant_b      <= 1'b0;
      is_write     <= 1'b0;
      ram_addr     <= '0;
      wdata_out    <= 8'd0;
      rd_data      <= 8'd0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      busy_q       <= 1'b0;
      buf_oe       <= 1'b0;
      buf_wr       <= 1'b0;
      cs_n         <= 1'b1;
      oe_n         <= 1'b1;
      we_n         <= 1'b1;
    end else begin
      wait_cnt     <= wait_cnt_nx;
      last_grant_b <= last_grant_b_nx;
      grant_b      <= grant_b_nx;
      is_write     <= is_write_nx;
      ram_addr     <= ram_addr_nx;
      wdata_out    <= wdata_out_nx;
      rd_data      <= rd_data_nx;
      ack_a        <= ack_a_nx;
      ack_b        <= ack_b_nx;
      busy_q       <= busy_nx;
      buf_oe       <= buf_oe_nx;
      buf_wr       <= buf_wr_nx;
      cs_n         <= cs_n_nx;
      oe_n         <= oe_n_nx;
      we_n         <= we_n_nx;
    end
  end

  assign bus.ackA     = ack_a;
  assign bus.ackB     = ack_b;
  assign bus.rdData   = rd_data;
  assign bus.busy     = busy_q;
  assign bus.bufOe    = buf_oe;
  assign bus.bufWr    = buf_wr;
  assign bus.wdataOut = wdata_out;
  assign bus.ramAddr  = ram_addr;
  assign bus.ramCs_n  = cs_n;
  assign bus.ramOe_n  = oe_n;
  assign bus.ramWe_n  = we_n;

endmodule

// File: tb/tb_mem_bus_controller.sv
// tb/tb_mem_bus_controller.sv - randomized bench for mem_bus_controller against a transaction-level model
module tb_mem_bus_controller;

  localparam int W  = 2;
  localparam int WE = (W < 1) ? 1 : W;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] dev_mem [logic [15:0]];
  logic [7:0] ref_mem [logic [15:0]];
  bit         m_last_b;
  logic [7:0] exp_rd;

  mem_bus_controller_if #(.ADDR_WIDTH(16)) bus ();

  mem_bus_controller #(.ADDR_WIDTH(16), .WAIT_STATES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h7C;
  endfunction

  function automatic logic [7:0] dev_read(input logic [15:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  // SRAM device behind the buffer plus bus-wide invariants
  always @(negedge clk) begin
    chk("excl_bufoe_bufwr", 32'(bus.bufOe & bus.bufWr), 0);
    chk("excl_ramoe_ramwe", 32'(!bus.ramOe_n & !bus.ramWe_n), 0);
    if (!bus.busy) chk("idle_buf_hiz", {30'd0, bus.bufOe, bus.bufWr}, 0);
    if (!bus.ramCs_n && !bus.ramWe_n) dev_mem[bus.ramAddr] = bus.wdataOut;
    bus.internalDataIn = (!bus.ramCs_n && !bus.ramOe_n) ? dev_read(bus.ramAddr) : 8'h00;
  end

  task automatic rand_ops(input bit port_b);
    if (port_b) begin
      bus.weB    = 1'($urandom_range(0, 1));
      bus.addrB  = 16'h0040 + 16'($urandom_range(0, 7));
      bus.wdataB = 8'($urandom);
    end else begin
      bus.weA    = 1'($urandom_range(0, 1));
      bus.addrA  = 16'h0040 + 16'($urandom_range(0, 7));
      bus.wdataA = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.reqA = 1'b0;
    bus.reqB = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ram_addr", 32'(bus.ramAddr), 0);
    chk("rst_wdata_out", 32'(bus.wdataOut), 0);
    chk("rst_rd_data", 32'(bus.rdData), 0);
    chk("rst_strobes_n", {29'd0, bus.ramCs_n, bus.ramOe_n, bus.ramWe_n}, 32'h7);
    chk("rst_buf_ack_busy", {27'd0, bus.bufOe, bus.bufWr, bus.ackA, bus.ackB, bus.busy}, 0);
    rst      = 1'b0;
    m_last_b = 1'b1;
    exp_rd   = 8'h00;
  endtask

  // called at an IDLE-cycle falling edge; leaves at the next IDLE-cycle falling edge
  task automatic xfer(input bit ra, input bit rb, input bit scramble);
    bit          win_b, we;
    logic [15:0] a;
    logic [7:0]  d, rd_exp;
    bus.reqA = ra;
    bus.reqB = rb;
    win_b    = rb && (!ra || !m_last_b);
    m_last_b = win_b;
    we       = win_b ? bus.weB    : bus.weA;
    a        = win_b ? bus.addrB  : bus.addrA;
    d        = win_b ? bus.wdataB : bus.wdataA;
    rd_exp   = ref_read(a);
    if (we) ref_mem[a] = d;
    for (int j = 1; j <= WE + 2; j++) begin
      @(negedge clk);
      if (scramble && j == 2) begin
        bus.addrA  = bus.addrA ^ 16'hFFFF;
        bus.wdataA = bus.wdataA ^ 8'hFF;
        bus.addrB  = bus.addrB ^ 16'hFFFF;
        bus.wdataB = bus.wdataB ^ 8'hFF;
      end
      if (j == WE + 2 && !we) exp_rd = rd_exp;
      chk("ram_cs_n", 32'(bus.ramCs_n), (j <= WE + 1) ? 0 : 1);
      chk("ram_oe_n", 32'(bus.ramOe_n), (!we && j <= WE + 1) ? 0 : 1);
      chk("ram_we_n", 32'(bus.ramWe_n), (we && j >= 2 && j <= WE + 1) ? 0 : 1);
      chk("buf_oe", 32'(bus.bufOe), (!we && j <= WE + 1) ? 1 : 0);
      chk("buf_wr", 32'(bus.bufWr), we ? 1 : 0);
      chk("ack_a", 32'(bus.ackA), (j == WE + 2 && !win_b) ? 1 : 0);
      chk("ack_b", 32'(bus.ackB), (j == WE + 2 && win_b) ? 1 : 0);
      chk("busy", 32'(bus.busy), 1);
      chk("ram_addr", 32'(bus.ramAddr), 32'(a));
      chk("rd_data", 32'(bus.rdData), 32'(exp_rd));
      if (we) chk("wdata_out", 32'(bus.wdataOut), 32'(d));
      if (j == WE + 2) begin
        if (win_b) bus.reqB = 1'b0;
        else       bus.reqA = 1'b0;
      end
    end
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_acks", {30'd0, bus.ackA, bus.ackB}, 0);
    chk("idle_rd_data", 32'(bus.rdData), 32'(exp_rd));
  endtask

  initial begin
    bit ra, rb;
    int r;
    rst = 1'b1;
    bus.reqA = 1'b0; bus.weA = 1'b0; bus.addrA = '0; bus.wdataA = '0;
    bus.reqB = 1'b0; bus.weB = 1'b0; bus.addrB = '0; bus.wdataB = '0;
    bus.internalDataIn = 8'h00;
    m_last_b = 1'b1;
    exp_rd   = 8'h00;
    do_reset();

    bus.weA = 1'b0; bus.addrA = 16'h1234; bus.wdataA = 8'h00;
    xfer(1'b1, 1'b0, 1'b0);
    chk("first_read_data", 32'(bus.rdData), 32'h5A);

    bus.weB = 1'b1; bus.addrB = 16'h00FF; bus.wdataB = 8'hC3;
    xfer(1'b0, 1'b1, 1'b0);

    do_reset();
    rand_ops(1'b0);
    rand_ops(1'b1);
    for (int i = 0; i < 4; i++) begin
      if (!bus.reqA) rand_ops(1'b0);
      if (!bus.reqB) rand_ops(1'b1);
      xfer(1'b1, 1'b1, 1'b0);
    end
    if (bus.reqB) xfer(1'b0, 1'b1, 1'b0);

    bus.weA = 1'b1; bus.addrA = 16'h0042; bus.wdataA = 8'h3C;
    xfer(1'b1, 1'b0, 1'b1);
    bus.weA = 1'b0; bus.addrA = 16'h0042;
    xfer(1'b1, 1'b0, 1'b1);

    bus.weA = 1'b1; bus.addrA = 16'h0BEE; bus.wdataA = 8'h77;
    ref_mem[16'h0BEE] = 8'h77;
    bus.reqA = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_pre_we_n", 32'(bus.ramWe_n), 0);
    #1 rst = 1'b1;
    #1;
    chk("abort_we_n", 32'(bus.ramWe_n), 1);
    chk("abort_cs_n", 32'(bus.ramCs_n), 1);
    chk("abort_buf_wr", 32'(bus.bufWr), 0);
    chk("abort_ack", {30'd0, bus.ackA, bus.ackB}, 0);
    bus.reqA = 1'b0;
    m_last_b = 1'b1;
    exp_rd   = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_ack", {30'd0, bus.ackA, bus.ackB}, 0);
    end
    rst = 1'b0;
    bus.weA = 1'b0; bus.addrA = 16'h0BEE;
    xfer(1'b1, 1'b0, 1'b0);
    chk("abort_readback", 32'(bus.rdData), 32'h77);

    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(0, 3));
      ra = r[0] || bus.reqA;
      rb = r[1] || bus.reqB;
      if (!ra && !rb) begin
        @(negedge clk);
        chk("rand_idle_busy", 32'(bus.busy), 0);
        chk("rand_idle_acks", {30'd0, bus.ackA, bus.ackB}, 0);
      end else begin
        if (ra && !bus.reqA) rand_ops(1'b0);
        if (rb && !bus.reqB) rand_ops(1'b1);
        xfer(ra, rb, 1'b0);
      end
    end
    if (bus.reqA) xfer(1'b1, 1'b0, 1'b0);
    if (bus.reqB) xfer(1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_controller.md
Name: mem_bus_controller

Overview:
- Sequences every external RAM cycle through the bidirectional RAM data buffer.
- Drives the buffer's oe/wr steering and the RAM's active-low strobes, with parameterised wait states and a turnaround cycle.
- Arbitrates round-robin between two requesters: port A (CPU core) and port B (DMA/debug loader).
- Sits between the core/DMA bus masters and the buffer plus off-chip SRAM.

Parameters:
ADDR_WIDTH, 16, width of request and RAM address
WAIT_STATES, 2, ACCESS-phase length in cycles (range 1-15; 0 is treated as 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
reqA  input  1  port A request, level
weA  input  1  port A write enable (1=write, 0=read)
addrA  input  ADDR_WIDTH  port A address
wdataA  input  8  port A write data
reqB  input  1  port B request, level
weB  input  1  port B write enable
addrB  input  ADDR_WIDTH  port B address
wdataB  input  8  port B write data
ackA  output  1  one-cycle completion pulse, port A
ackB  output  1  one-cycle completion pulse, port B
rdData  output  8  read data, valid from the ack cycle until the next read completes
busy  output  1  high in any state except IDLE
bufOe  output  1  buffer oe (external to internal)
bufWr  output  1  buffer wr (internal to external)
wdataOut  output  8  data presented on the internal side of the buffer
internalDataIn  input  8  internal-side data from the buffer, for reads
ramAddr  output  ADDR_WIDTH  registered RAM address
ramCs_n  output  1  RAM chip select, active low
ramOe_n  output  1  RAM output enable, active low
ramWe_n  output  1  RAM write enable, active low

Behaviour:
- All outputs are registered. Reset, while asserted, forces:
  - FSM = IDLE; lastGrant = B, so A wins the first tie.
  - ack* = 0, bufOe = bufWr = 0, ram*_n = 1.
  - ramAddr = 0, wdataOut = 0, rdData = 0, busy = 0, wait counter = 0.
- Reset mid-cycle aborts the transfer immediately. No ack is issued, and the buffer tristates.
- States:
  - IDLE -> SETUP when reqA or reqB is sampled high.
  - SETUP -> ACCESS after 1 cycle.
  - ACCESS -> TURN after WAIT_STATES cycles.
  - TURN -> IDLE after 1 cycle.
- Arbitration happens only in IDLE:
  - Single requester wins.
  - Both requesting: the port other than lastGrant wins, and lastGrant updates to the winner.
  - The winner's we, addr and wdata are captured at the IDLE->SETUP edge. Later changes to them are ignored.
- Read cycle:
  - SETUP: ramCs_n = 0, ramOe_n = 0, bufOe = 1, bufWr = 0.
  - ACCESS: same outputs held.
  - rdData captures internalDataIn on the edge leaving the last ACCESS cycle.
- Write cycle:
  - SETUP: ramCs_n = 0, bufWr = 1, bufOe = 0, wdataOut valid, ramWe_n = 1.
  - ACCESS: ramWe_n = 0.
  - TURN: ramWe_n = 1 while bufWr stays 1 for data hold.
- TURN, both cycle types:
  - ramCs_n = 1 and ramOe_n = 1.
  - bufOe = 0.
  - The winner's ack = 1 for exactly this cycle.
- IDLE: bufOe = bufWr = 0, so the buffer is high-Z on both sides.
- bufOe and bufWr are never both 1. ramOe_n and ramWe_n are never both 0.
- Latency: req sampled at edge k -> SETUP in cycle k+1, ACCESS in cycles k+2..k+1+WAIT_STATES, ack in cycle k+2+WAIT_STATES. Back-to-back transfer period is WAIT_STATES+3 cycles.
- Requester protocol:
  - Hold req and operands stable until ack.
  - Drop req by the edge ending the ack cycle, or the request is treated as a new transfer.
- A request arriving during busy waits in place; it is sampled in the next IDLE. There is no starvation: an alternating grant is guaranteed under continuous dual requests.

Test Plan:
- Reset then single A read (addrA=0x1234, RAM model drives 0x5A, WAIT_STATES=2) -> ramAddr=0x1234, ramOe_n low for 3 cycles, ackA in 4th cycle after sampling, rdData=0x5A, ackB never high.
- B write (addrB=0x00FF, wdataB=0xC3) -> bufWr high for SETUP through TURN; ramWe_n low exactly 2 cycles; wdataOut=0xC3 throughout; bufOe stays 0; ackB one pulse.
- reqA and reqB high together from reset, held with re-requests -> grant order A, B, A, B; each ack 5 cycles apart (WAIT_STATES=2).
- Change addrA/wdataA during ACCESS -> ramAddr and wdataOut keep their captured values.
- Assert rst during a write's ACCESS -> ramWe_n=1, ramCs_n=1, bufWr=0 asynchronously, no ack; after release a new A read completes normally.
- Every cycle of all tests: assert !(bufOe && bufWr), !(!ramOe_n && !ramWe_n), and bufOe=bufWr=0 in IDLE.
